// File: rtl/system86_video_pkg.sv
// Shared video timing constants, counter width and window-decode helpers.
// Latency: n/a (package). Backpressure: n/a; the raster never stalls.
// Contents: CNT_W, MAX_TOTAL, DEF_* default timings, in_blank(), in_sync().
package system86_video_pkg;

  localparam int CNT_W     = 9;
  localparam int MAX_TOTAL = 1 << CNT_W;

  localparam int DEF_H_TOTAL       = 384;
  localparam int DEF_H_BLANK_START = 355;
  localparam int DEF_H_BLANK_END   = 67;
  localparam int DEF_HSYNC_START   = 0;
  localparam int DEF_HSYNC_END     = 31;
  localparam int DEF_V_TOTAL       = 264;
  localparam int DEF_V_BLANK_START = 240;
  localparam int DEF_V_BLANK_END   = 16;
  localparam int DEF_VSYNC_START   = 248;
  localparam int DEF_VSYNC_END     = 251;

  // Half-open blank window [s, e); when s > e the window wraps through 0.
  function automatic logic in_blank(input logic [CNT_W-1:0] val, input int s, input int e);
    int x;
    x = int'(val);
    if (s <= e) return (x >= s) && (x < e);
    else        return (x >= s) || (x < e);
  endfunction

  // Inclusive sync window [s, e]; when s > e the window wraps through 0.
  function automatic logic in_sync(input logic [CNT_W-1:0] val, input int s, input int e);
    int x;
    x = int'(val);
    if (s <= e) return (x >= s) && (x <= e);
    else        return (x >= s) || (x <= e);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter with enable; exposes next value for registered decode.
// Latency: count updates on the clock edge after en; count_nxt/wrap are combinational.
// Backpressure: none; en simply holds the count.
// Ports: clk, rst_n (async active-low), en | count, count_nxt, wrap (en && count==MODULUS-1).
module mod_counter
  import system86_video_pkg::*;
#(
  parameter int MODULUS = DEF_H_TOTAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt,
  output logic             wrap
);

  logic at_top;

  assign at_top = (count == CNT_W'(MODULUS - 1));
  assign wrap   = en && at_top;

  always_comb begin
    count_nxt = count;
    if (en) count_nxt = at_top ? '0 : count + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count_nxt;
  end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: H/V counters plus blank, sync and line/frame strobes.
// Latency: every flag is registered from next-state counts, so it lines up with the H/V it describes.
// Backpressure: none; free-running on CLK_6M.
// Ports: CLK_6M, nRST | H, V, CLK_1H, CLK_2H, nHBLK, nVBLK, nHSYNC, nVSYNC, HLINE, VBLK_START
//        and FRAME (8-bit frame counter) only when VIDEO_TIMING_FRAME_CNT_EN is defined.
module video_timing
  import system86_video_pkg::*;
#(
  parameter int H_TOTAL       = DEF_H_TOTAL,
  parameter int H_BLANK_START = DEF_H_BLANK_START,
  parameter int H_BLANK_END   = DEF_H_BLANK_END,
  parameter int HSYNC_START   = DEF_HSYNC_START,
  parameter int HSYNC_END     = DEF_HSYNC_END,
  parameter int V_TOTAL       = DEF_V_TOTAL,
  parameter int V_BLANK_START = DEF_V_BLANK_START,
  parameter int V_BLANK_END   = DEF_V_BLANK_END,
  parameter int VSYNC_START   = DEF_VSYNC_START,
  parameter int VSYNC_END     = DEF_VSYNC_END
) (
  input  logic             CLK_6M,
  input  logic             nRST,
  output logic [CNT_W-1:0] H,
  output logic [CNT_W-1:0] V,
  output logic             CLK_1H,
  output logic             CLK_2H,
  output logic             nHBLK,
  output logic             nVBLK,
  output logic             nHSYNC,
  output logic             nVSYNC,
  output logic             HLINE,
  output logic             VBLK_START
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0]       FRAME
`endif
);

  if (H_TOTAL < 2 || H_TOTAL > MAX_TOTAL || V_TOTAL < 2 || V_TOTAL > MAX_TOTAL ||
      H_BLANK_START < 0 || H_BLANK_START >= H_TOTAL || H_BLANK_END < 0 || H_BLANK_END >= H_TOTAL ||
      HSYNC_START < 0 || HSYNC_START >= H_TOTAL || HSYNC_END < 0 || HSYNC_END >= H_TOTAL ||
      V_BLANK_START < 0 || V_BLANK_START >= V_TOTAL || V_BLANK_END < 0 || V_BLANK_END >= V_TOTAL ||
      VSYNC_START < 0 || VSYNC_START >= V_TOTAL || VSYNC_END < 0 || VSYNC_END >= V_TOTAL) begin : g_bad_param
    $error("video_timing: timing parameter out of range");
  end

  // Flag values while in reset are the decode of H=0/V=0, except HLINE which is held low.
  localparam logic RST_NHBLK  = !in_blank(CNT_W'(0), H_BLANK_START, H_BLANK_END);
  localparam logic RST_NVBLK  = !in_blank(CNT_W'(0), V_BLANK_START, V_BLANK_END);
  localparam logic RST_NHSYNC = !in_sync(CNT_W'(0), HSYNC_START, HSYNC_END);
  localparam logic RST_NVSYNC = !in_sync(CNT_W'(0), VSYNC_START, VSYNC_END);

  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_wrap;
  logic             v_wrap;

  mod_counter #(.MODULUS(H_TOTAL)) u_hcnt (
    .clk      (CLK_6M),
    .rst_n    (nRST),
    .en       (1'b1),
    .count    (H),
    .count_nxt(h_nxt),
    .wrap     (h_wrap)
  );

  mod_counter #(.MODULUS(V_TOTAL)) u_vcnt (
    .clk      (CLK_6M),
    .rst_n    (nRST),
    .en       (h_wrap),
    .count    (V),
    .count_nxt(v_nxt),
    .wrap     (v_wrap)
  );

  // Straight flop bits, so these dividers cannot glitch.
  assign CLK_1H = H[0];
  assign CLK_2H = H[1];

  // Decode from the values the counters are about to take so the flag flops
  // change on the same edge as the counters.
  always_ff @(posedge CLK_6M or negedge nRST) begin
    if (!nRST) begin
      nHBLK      <= RST_NHBLK;
      nVBLK      <= RST_NVBLK;
      nHSYNC     <= RST_NHSYNC;
      nVSYNC     <= RST_NVSYNC;
      HLINE      <= 1'b0;
      VBLK_START <= 1'b0;
    end else begin
      nHBLK      <= !in_blank(h_nxt, H_BLANK_START, H_BLANK_END);
      nVBLK      <= !in_blank(v_nxt, V_BLANK_START, V_BLANK_END);
      nHSYNC     <= !in_sync(h_nxt, HSYNC_START, HSYNC_END);
      nVSYNC     <= !in_sync(v_nxt, VSYNC_START, VSYNC_END);
      HLINE      <= (h_nxt == '0);
      VBLK_START <= (h_nxt == '0) && (v_nxt == CNT_W'(V_BLANK_START));
    end
  end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  always_ff @(posedge CLK_6M or negedge nRST) begin
    if (!nRST)       FRAME <= 8'd0;
    else if (v_wrap) FRAME <= FRAME + 8'd1;
  end
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing. H timing uses the default parameters; the
// frame is shortened to 20 lines (blank 16..2, sync 17..18) to keep runtime small.
module tb_video_timing;

  localparam int HT        = 384;
  localparam int VT        = 20;
  localparam int VBS       = 16;
  localparam int VBE       = 3;
  localparam int VSS       = 17;
  localparam int VSE       = 18;
  localparam int FRAME_CYC = HT * VT;  // 7680

  logic       CLK_6M;
  logic       nRST;
  logic [8:0] H;
  logic [8:0] V;
  logic       CLK_1H, CLK_2H, nHBLK, nVBLK, nHSYNC, nVSYNC, HLINE, VBLK_START;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [7:0] FRAME;
`endif

  int checks = 0;
  int errors = 0;
  int exp_h  = 0;
  int exp_v  = 0;

  video_timing #(
    .V_TOTAL(VT), .V_BLANK_START(VBS), .V_BLANK_END(VBE),
    .VSYNC_START(VSS), .VSYNC_END(VSE)
  ) dut (
    .CLK_6M    (CLK_6M),
    .nRST      (nRST),
    .H         (H),
    .V         (V),
    .CLK_1H    (CLK_1H),
    .CLK_2H    (CLK_2H),
    .nHBLK     (nHBLK),
    .nVBLK     (nVBLK),
    .nHSYNC    (nHSYNC),
    .nVSYNC    (nVSYNC),
    .HLINE     (HLINE),
    .VBLK_START(VBLK_START)
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    ,
    .FRAME     (FRAME)
`endif
  );

  initial begin
    CLK_6M = 1'b0;
    forever #5 CLK_6M = ~CLK_6M;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: sample on the falling edge and advance the expected position.
  task automatic step();
    @(negedge CLK_6M);
    exp_h = (exp_h + 1) % HT;
    if (exp_h == 0) exp_v = (exp_v + 1) % VT;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(negedge CLK_6M);
    checks++;
    if (H !== 9'd0 || V !== 9'd0) begin
      errors++; $display("FAIL reset_counters: H=%0d V=%0d required 0 0", H, V);
    end
    checks++;
    if ({nHBLK, nVBLK, nHSYNC, nVSYNC, HLINE, VBLK_START} !== 6'b000100) begin
      errors++; $display("FAIL reset_flags: got %b required 000100",
                         {nHBLK, nVBLK, nHSYNC, nVSYNC, HLINE, VBLK_START});
    end
    checks++;
    if (CLK_1H !== 1'b0 || CLK_2H !== 1'b0) begin
      errors++; $display("FAIL reset_clkdiv: 1H=%b 2H=%b required 0 0", CLK_1H, CLK_2H);
    end
    nRST  = 1'b1;
    exp_h = 0;
    exp_v = 0;
    step();
    checks++;
    if (H !== 9'd1 || V !== 9'd0 || HLINE !== 1'b0) begin
      errors++; $display("FAIL first_edge: H=%0d V=%0d HLINE=%b required 1 0 0", H, V, HLINE);
    end
  endtask

  // One full line starting at H=1: per-cycle sequence and flag decode, plus window lengths.
  task automatic test_line_scan();
    int   hblk_low = 0, hsync_low = 0, hline_cnt = 0;
    logic e_hblk, e_hsync;
    for (int c = 0; c < HT; c++) begin
      step();
      e_hblk  = !((exp_h >= 355) || (exp_h < 67));
      e_hsync = !(exp_h <= 31);
      if (!nHBLK)  hblk_low++;
      if (!nHSYNC) hsync_low++;
      if (HLINE)   hline_cnt++;
      checks++;
      if (H !== 9'(exp_h) || V !== 9'(exp_v) || HLINE !== (exp_h == 0) ||
          nHBLK !== e_hblk || nHSYNC !== e_hsync) begin
        errors++;
        $display("FAIL line_seq: H=%0d V=%0d HLINE=%b nHBLK=%b nHSYNC=%b required %0d %0d %b %b %b",
                 H, V, HLINE, nHBLK, nHSYNC, exp_h, exp_v, (exp_h == 0), e_hblk, e_hsync);
        break;
      end
    end
    checks++;
    if (V !== 9'd1) begin
      errors++; $display("FAIL line_vinc: V=%0d required 1", V);
    end
    checks++;
    if (hblk_low !== 96) begin
      errors++; $display("FAIL hblank_len: %0d cycles required 96", hblk_low);
    end
    checks++;
    if (hsync_low !== 32) begin
      errors++; $display("FAIL hsync_len: %0d cycles required 32", hsync_low);
    end
    checks++;
    if (hline_cnt !== 1) begin
      errors++; $display("FAIL hline_count: %0d pulses required 1", hline_cnt);
    end
  endtask

  task automatic test_clk2h();
    int   high = 0, rises = 0, last_rise = -1, bad_gap = 0;
    logic prev;
    prev = CLK_2H;
    for (int c = 0; c < 64; c++) begin
      step();
      checks++;
      if (CLK_2H !== exp_h[1] || CLK_1H !== exp_h[0]) begin
        errors++;
        $display("FAIL clkdiv_bits: 1H=%b 2H=%b required %b %b", CLK_1H, CLK_2H, exp_h[0], exp_h[1]);
        break;
      end
      if (CLK_2H) high++;
      if (CLK_2H && !prev) begin
        if (last_rise >= 0 && c - last_rise != 4) bad_gap++;
        last_rise = c;
        rises++;
      end
      prev = CLK_2H;
    end
    checks++;
    if (high !== 32 || rises !== 16 || bad_gap !== 0) begin
      errors++; $display("FAIL clk2h_shape: high=%0d rises=%0d bad_gaps=%0d required 32 16 0",
                         high, rises, bad_gap);
    end
  endtask

  task automatic test_vblank();
    int   fall1 = -1, fall2 = -1, vs_low = 0, vstart_cnt = 0;
    bit   rise_seen = 0;
    logic prev;
    prev = nVBLK;
    for (int c = 0; c < 2 * FRAME_CYC + 16; c++) begin
      step();
      if (prev && !nVBLK) begin
        if (fall1 < 0) begin
          fall1 = c;
          checks++;
          if (H !== 9'd0 || V !== 9'(VBS) || VBLK_START !== 1'b1) begin
            errors++; $display("FAIL vblk_fall: H=%0d V=%0d VBLK_START=%b required 0 %0d 1",
                               H, V, VBLK_START, VBS);
          end
        end else begin
          fall2 = c;
        end
      end
      if (!prev && nVBLK && fall1 >= 0 && !rise_seen) begin
        rise_seen = 1;
        checks++;
        if (H !== 9'd0 || V !== 9'(VBE)) begin
          errors++; $display("FAIL vblk_rise: H=%0d V=%0d required 0 %0d", H, V, VBE);
        end
      end
      if (fall1 >= 0 && fall2 < 0) begin
        if (VBLK_START) vstart_cnt++;
        if (!nVSYNC)    vs_low++;
      end
      prev = nVBLK;
      if (fall2 >= 0) break;
    end
    checks++;
    if (fall2 < 0 || fall2 - fall1 != FRAME_CYC) begin
      errors++; $display("FAIL frame_period: %0d cycles required %0d", fall2 - fall1, FRAME_CYC);
    end
    checks++;
    if (vstart_cnt !== 1) begin
      errors++; $display("FAIL vblk_start_count: %0d pulses required 1", vstart_cnt);
    end
    checks++;
    if (vs_low !== 2 * HT) begin
      errors++; $display("FAIL vsync_len: %0d cycles required %0d", vs_low, 2 * HT);
    end
    checks++;
    if (!rise_seen) begin
      errors++; $display("FAIL vblk_rise_seen: got 0 required 1");
    end
  endtask

  task automatic test_async_reset();
    int early   = 0;
    bit reached = 0;
    for (int c = 0; c < 2 * FRAME_CYC && !(exp_h == 200 && exp_v == 10); c++) step();
    checks++;
    if (H !== 9'd200 || V !== 9'd10 || {nHBLK, nVBLK, nHSYNC} !== 3'b111) begin
      errors++; $display("FAIL pre_reset_pos: H=%0d V=%0d flags=%b required 200 10 111",
                         H, V, {nHBLK, nVBLK, nHSYNC});
    end
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (H !== 9'd0 || V !== 9'd0 ||
        {nHBLK, nVBLK, nHSYNC, nVSYNC, HLINE, VBLK_START} !== 6'b000100) begin
      errors++; $display("FAIL async_reset: H=%0d V=%0d flags=%b required 0 0 000100",
                         H, V, {nHBLK, nVBLK, nHSYNC, nVSYNC, HLINE, VBLK_START});
    end
    repeat (3) @(negedge CLK_6M);
    nRST  = 1'b1;
    exp_h = 0;
    exp_v = 0;
    step();
    checks++;
    if (H !== 9'd1 || V !== 9'd0) begin
      errors++; $display("FAIL post_reset_edge: H=%0d V=%0d required 1 0", H, V);
    end
    for (int c = 0; c < FRAME_CYC; c++) begin
      step();
      if (exp_h == 0 && exp_v == VBS) begin
        reached = 1;
        break;
      end
      if (VBLK_START !== 1'b0) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++; $display("FAIL early_vblk_start: %0d pulses required 0", early);
    end
    checks++;
    if (!reached || VBLK_START !== 1'b1 || H !== 9'd0 || V !== 9'(VBS)) begin
      errors++; $display("FAIL vblk_start_after_reset: H=%0d V=%0d VBLK_START=%b required 0 %0d 1",
                         H, V, VBLK_START, VBS);
    end
  endtask

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  task automatic test_frame_cnt();
    checks++;
    if (FRAME !== 8'd0) begin
      errors++; $display("FAIL frame_after_reset: %0d required 0", FRAME);
    end
    for (int c = 0; c < FRAME_CYC && !(exp_h == 0 && exp_v == 0); c++) step();
    checks++;
    if (FRAME !== 8'd1 || H !== 9'd0 || V !== 9'd0) begin
      errors++; $display("FAIL frame_first_wrap: FRAME=%0d H=%0d V=%0d required 1 0 0", FRAME, H, V);
    end
    repeat (FRAME_CYC - 1) step();
    checks++;
    if (FRAME !== 8'd1) begin
      errors++; $display("FAIL frame_hold: %0d required 1", FRAME);
    end
    step();
    checks++;
    if (FRAME !== 8'd2 || V !== 9'd0) begin
      errors++; $display("FAIL frame_second_wrap: FRAME=%0d V=%0d required 2 0", FRAME, V);
    end
  endtask
`endif

  initial begin
    nRST = 1'b0;
    test_reset();
    test_line_scan();
    test_clk2h();
    test_vblank();
    test_async_reset();
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 SHALL provide parameter H_TOTAL, default 384, pixels per line.
REQ-002 SHALL provide parameter H_BLANK_START, default 355, first blanked H count.
REQ-003 SHALL provide parameter H_BLANK_END, default 67, first active H count.
REQ-004 SHALL provide parameters HSYNC_START and HSYNC_END, defaults 0 and 31, inclusive sync window.
REQ-005 SHALL provide parameter V_TOTAL, default 264, lines per frame.
REQ-006 SHALL provide parameters V_BLANK_START and V_BLANK_END, defaults 240 and 16.
REQ-007 SHALL provide parameters VSYNC_START and VSYNC_END, defaults 248 and 251, inclusive sync window.
REQ-008 SHALL have port CLK_6M  input  1  6.144 MHz pixel clock; all state changes on its rising edge.
REQ-009 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-010 SHALL have port H  output  9  horizontal pixel count.
REQ-011 SHALL have port V  output  9  vertical line count.
REQ-012 SHALL have port CLK_1H  output  1  equal to H[0].
REQ-013 SHALL have port CLK_2H  output  1  equal to H[1]; feeds the secondary-CPU phase generator.
REQ-014 SHALL have port nHBLK  output  1  low during horizontal blank.
REQ-015 SHALL have port nVBLK  output  1  low during vertical blank; feeds the sub-CPU IRQ generator.
REQ-016 SHALL have ports nHSYNC and nVSYNC  output  1 each  low inside the sync windows.
REQ-017 SHALL have port HLINE  output  1  one-cycle high pulse while H==0.
REQ-018 SHALL have port VBLK_START  output  1  one-cycle high pulse while H==0 and V==V_BLANK_START.

Function
REQ-019 H SHALL increment by 1 each cycle and wrap from H_TOTAL-1 to 0.
REQ-020 V SHALL increment only on the cycle where H wraps; V SHALL wrap from V_TOTAL-1 to 0 on that same cycle.
REQ-021 nHBLK SHALL be low when H>=H_BLANK_START or H<H_BLANK_END; otherwise high.
REQ-022 nVBLK SHALL be low when V>=V_BLANK_START or V<V_BLANK_END; otherwise high.
REQ-023 Sync outputs SHALL be low when the counter lies within [START,END] inclusive.
REQ-024 All flag outputs SHALL be registered, decoded from next-state counter values, and coincident with the H/V value they describe (zero cycles skew, glitch-free).
REQ-025 Blank/sync windows SHALL handle wrap-around (START>END) as the union of the two ranges.
REQ-026 Counter widths SHALL be 9 bits; H_TOTAL and V_TOTAL SHALL be <=512; out-of-range parameters SHALL be caught by an elaboration-time check.
REQ-027 Frame length SHALL be exactly H_TOTAL*V_TOTAL cycles (101376 at defaults).

Reset
REQ-028 Asserting nRST SHALL immediately force H=0, V=0, nHBLK=0, nVBLK=0, nHSYNC=0 (per defaults), nVSYNC=1, HLINE=0, VBLK_START=0.
REQ-029 The first rising edge after nRST deasserts SHALL advance H to 1; reset asserted mid-frame SHALL abandon the frame with no partial pulses.

Configuration
REQ-030 With VIDEO_TIMING_FRAME_CNT_EN defined, SHALL add output FRAME (8 bits), reset 0, incrementing modulo 256 on each V wrap.
REQ-031 Without VIDEO_TIMING_FRAME_CNT_EN, the FRAME port and its counter SHALL be absent; all other behaviour is unchanged.

Structure
REQ-032 Default timing constants and the 9-bit counter width SHALL live in shared package system86_video_pkg.
REQ-033 A sub-module mod_counter (parameterised modulus, enable in, wrap out) SHALL be instantiated once for H and once for V.

Verification
REQ-034 Release nRST, run 384 cycles -> H goes 0..383 then back to 0; V increments 0->1 on the wrap; HLINE high exactly at H==0.
REQ-035 Full frame -> nVBLK falls at H=0, V=240 with a single-cycle VBLK_START; rises at V=16; period 101376 cycles.
REQ-036 Line scan -> nHBLK low for H 355..383 and 0..66 (96 cycles); nHSYNC low for H 0..31.
REQ-037 Assert nRST at H=200, V=150 asynchronously -> outputs take reset values before the next edge; no VBLK_START until V=240.
REQ-038 With VIDEO_TIMING_FRAME_CNT_EN, run 257 frames -> FRAME wraps 255->0 at the V wrap; without it, the build has no FRAME port.
REQ-039 CLK_2H checked against H[1] every cycle -> period 4 cycles, 50% duty, no glitches.
